// File: rtl/param_microprocessor_core_if.sv
// param_microprocessor_core_if: instruction-fetch request/valid bus between the core and instruction memory
// Ports (master = core, slave = instruction memory):
//   instr_req   request, held high while the core waits for an instruction
//   instr_addr  fetch address (the program counter)
//   instr_valid instruction word valid
//   instr_data  instruction word, IW bits wide
interface param_microprocessor_core_if #(
  parameter int PC_W = 8,
  parameter int IW   = 8
);
  logic            instr_req;
  logic [PC_W-1:0] instr_addr;
  logic            instr_valid;
  logic [IW-1:0]   instr_data;
  modport master (output instr_req, instr_addr, input instr_valid, instr_data);
  modport slave  (input instr_req, instr_addr, output instr_valid, instr_data);
endinterface

// File: rtl/param_microprocessor_core.sv
// param_microprocessor_core: parametrised multi-cycle load/store core (ADD, LOAD, STORE, BEQ)
// Ports:
//   clock, reset      system clock; asynchronous active-high reset
//   run               1 = fetch the next instruction, 0 = pause in FETCH
//   ibus              instruction-fetch handshake (master side)
//   console_data      last register write-back value
//   console_valid     one-cycle pulse after each register write
//   instr_count       retired-instruction counter, wraps
//   dbg_sel, dbg_data combinational debug read of a register
module param_microprocessor_core #(
  parameter int DATA_W     = 8,
  parameter int RA_W       = 2,
  parameter int PC_W       = 8,
  parameter int DMEM_DEPTH = 32,
  parameter bit ZERO_REG   = 1'b0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             run,
  param_microprocessor_core_if.master      ibus,
  output logic [DATA_W-1:0]                console_data,
  output logic                             console_valid,
  output logic [15:0]                      instr_count,
  input  logic [RA_W-1:0]                  dbg_sel,
  output logic [DATA_W-1:0]                dbg_data
);
  localparam int IW = 2 + 3 * RA_W;
  localparam int NR = 1 << RA_W;
  localparam int AW = $clog2(DMEM_DEPTH);
  typedef enum logic [1:0] {FETCH, WAIT, EXEC} state_t;
  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] cdata_q, cdata_d;
  logic              cvalid_q, cvalid_d;
  logic [DATA_W-1:0] gpr_q [NR];
  logic [DATA_W-1:0] gpr_d [NR];
  logic [DATA_W-1:0] mem_q [DMEM_DEPTH];
  logic [DATA_W-1:0] mem_d [DMEM_DEPTH];
  logic [1:0]        op;
  logic [RA_W-1:0]   rs, rt, rd, wa;
  logic [DATA_W-1:0] rs_v, rt_v, imm_x, wv;
  logic [AW-1:0]     addr;
  logic              wen, taken;
  // Decode and operand read; GPR reads in EXEC see pre-write values.
  always_comb begin
    {op, rs, rt, rd} = ir_q;
    rs_v     = (ZERO_REG && rs == '0) ? '0 : gpr_q[rs];
    rt_v     = (ZERO_REG && rt == '0) ? '0 : gpr_q[rt];
    dbg_data = (ZERO_REG && dbg_sel == '0) ? '0 : gpr_q[dbg_sel];
    imm_x    = {{(DATA_W-RA_W){rd[RA_W-1]}}, rd};
    addr     = AW'(rs_v + imm_x);
    wa       = op[0] ? rt : rd;
    wv       = op[0] ? mem_q[addr] : rs_v + rt_v;
    // ADD and LOAD write back; a write to r0 is dropped entirely when r0 is hard-wired.
    wen      = state_q == EXEC && !op[1] && !(ZERO_REG && wa == '0);
    taken    = op == 2'b11 && rs_v == rt_v;
  end
  always_comb begin
    state_d = state_q == FETCH ? (run ? WAIT : FETCH) :
              state_q == WAIT  ? (ibus.instr_valid ? EXEC : WAIT) : FETCH;
  end
  always_comb begin
    pc_d     = state_q == EXEC ? pc_q + PC_W'(1) + (taken ? {{(PC_W-RA_W){rd[RA_W-1]}}, rd} : '0) : pc_q;
    ir_d     = (state_q == WAIT && ibus.instr_valid) ? ibus.instr_data : ir_q;
    cnt_d    = state_q == EXEC ? cnt_q + 16'd1 : cnt_q;
    cvalid_d = wen;
    cdata_d  = wen ? wv : cdata_q;
    gpr_d    = gpr_q;
    mem_d    = mem_q;
    if (wen) gpr_d[wa] = wv;
    if (state_q == EXEC && op == 2'b10) mem_d[addr] = rt_v;
  end
  always_comb begin
    ibus.instr_req  = state_q == WAIT;
    ibus.instr_addr = pc_q;
    console_data    = cdata_q;
    console_valid   = cvalid_q;
    instr_count     = cnt_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= FETCH;
    else state_q <= state_d;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      ir_q     <= '0;
      cnt_q    <= '0;
      cdata_q  <= '0;
      cvalid_q <= 1'b0;
      for (int i = 0; i < NR; i++) gpr_q[i] <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) mem_q[i] <= DATA_W'(i);
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      cdata_q  <= cdata_d;
      cvalid_q <= cvalid_d;
      gpr_q    <= gpr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: tb/tb_param_microprocessor_core.sv
// tb_param_microprocessor_core: directed checks of the default core, a ZERO_REG=1 core and a 16-bit/8-register core
module tb_param_microprocessor_core;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic [2:0] dbg_sel = '0;
  logic [7:0] cd0, cd1, dd0, dd1;
  logic [15:0] cd2, dd2;
  logic cv0, cv1, cv2;
  logic [15:0] ic0, ic1, ic2;
  int n_chk = 0, n_pass = 0, n_fail = 0;

  always #5 clock = ~clock;

  param_microprocessor_core_if #(.PC_W(8), .IW(8))  b0 ();
  param_microprocessor_core_if #(.PC_W(8), .IW(8))  b1 ();
  param_microprocessor_core_if #(.PC_W(8), .IW(11)) b2 ();

  param_microprocessor_core #(.ZERO_REG(1'b0)) u0 (
    .clock(clock), .reset(reset), .run(run), .ibus(b0), .console_data(cd0), .console_valid(cv0),
    .instr_count(ic0), .dbg_sel(dbg_sel[1:0]), .dbg_data(dd0));
  param_microprocessor_core #(.ZERO_REG(1'b1)) u1 (
    .clock(clock), .reset(reset), .run(run), .ibus(b1), .console_data(cd1), .console_valid(cv1),
    .instr_count(ic1), .dbg_sel(dbg_sel[1:0]), .dbg_data(dd1));
  param_microprocessor_core #(.DATA_W(16), .RA_W(3), .DMEM_DEPTH(64)) u2 (
    .clock(clock), .reset(reset), .run(run), .ibus(b2), .console_data(cd2), .console_valid(cv2),
    .instr_count(ic2), .dbg_sel(dbg_sel), .dbg_data(dd2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (%0d failed)", tag, obs, exp, n_fail);
    end
  endtask

  function automatic logic req(input int k);
    return k == 0 ? b0.instr_req : k == 1 ? b1.instr_req : b2.instr_req;
  endfunction

  // Waits (bounded) for the core's request, presents the word for one edge, then lets EXEC retire.
  task automatic exec(input int k, input logic [10:0] d);
    int t = 0;
    while (req(k) !== 1'b1 && t < 20) begin
      @(negedge clock);
      t++;
    end
    chk("fetch_req", 32'(req(k)), 1);
    if (k == 0) begin b0.instr_data = d[7:0]; b0.instr_valid = 1'b1; end
    else if (k == 1) begin b1.instr_data = d[7:0]; b1.instr_valid = 1'b1; end
    else begin b2.instr_data = d; b2.instr_valid = 1'b1; end
    @(negedge clock);
    b0.instr_valid = 1'b0;
    b1.instr_valid = 1'b0;
    b2.instr_valid = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    b0.instr_valid = 1'b0; b0.instr_data = '0;
    b1.instr_valid = 1'b0; b1.instr_data = '0;
    b2.instr_valid = 1'b0; b2.instr_data = '0;
    #3;
    chk("rst_req", 32'(b0.instr_req), 0);
    chk("rst_addr", 32'(b0.instr_addr), 0);
    chk("rst_cvalid", 32'(cv0), 0);
    chk("rst_cdata", 32'(cd0), 0);
    chk("rst_cnt", 32'(ic0), 0);
    chk("rst_cnt_wide", 32'(ic2), 0);
    @(negedge clock);
    reset = 1'b0;
    run = 1'b1;
    exec(0, 11'h46);
    chk("ld_cvalid", 32'(cv0), 1);
    chk("ld_cdata", 32'(cd0), 'h1E);
    chk("ld_cnt", 32'(ic0), 1);
    chk("ld_pc", 32'(b0.instr_addr), 1);
    dbg_sel = 3'd1;
    #1 chk("ld_dbg_r1", 32'(dd0), 'h1E);
    exec(0, 11'h15);
    chk("add_cdata", 32'(cd0), 'h3C);
    chk("add_cvalid", 32'(cv0), 1);
    @(negedge clock);
    chk("pulse_one_cycle", 32'(cv0), 0);
    exec(0, 11'h94);
    chk("st_no_pulse", 32'(cv0), 0);
    chk("st_pc", 32'(b0.instr_addr), 3);
    exec(0, 11'h58);
    chk("ld_after_st", 32'(cd0), 'h3C);
    dbg_sel = 3'd2;
    #1 chk("ld_dbg_r2", 32'(dd0), 'h3C);
    exec(0, 11'h03);
    chk("add_zero_cdata", 32'(cd0), 0);
    chk("add_zero_pc", 32'(b0.instr_addr), 5);
    exec(0, 11'hC1);
    chk("beq_taken_pc", 32'(b0.instr_addr), 7);
    chk("beq_no_pulse", 32'(cv0), 0);
    exec(0, 11'hC7);
    chk("beq_not_taken_pc", 32'(b0.instr_addr), 8);
    chk("beq_cnt", 32'(ic0), 7);
    @(negedge clock);
    repeat (5) @(negedge clock);
    chk("stall_req", 32'(b0.instr_req), 1);
    chk("stall_cnt", 32'(ic0), 7);
    chk("stall_addr", 32'(b0.instr_addr), 8);
    #2 reset = 1'b1;
    dbg_sel = 3'd1;
    #1;
    chk("async_rst_req", 32'(b0.instr_req), 0);
    chk("async_rst_addr", 32'(b0.instr_addr), 0);
    chk("async_rst_cnt", 32'(ic0), 0);
    chk("async_rst_r1", 32'(dd0), 0);
    run = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("paused_req", 32'(b0.instr_req), 0);
    run = 1'b1;
    @(negedge clock);
    chk("refetch_req", 32'(b0.instr_req), 1);
    chk("refetch_addr", 32'(b0.instr_addr), 0);
    exec(0, 11'hC2);
    chk("beq_back_pc", 32'(b0.instr_addr), 'hFF);
    exec(0, 11'hC1);
    chk("beq_wrap_pc", 32'(b0.instr_addr), 1);
    chk("beq_wrap_cnt", 32'(ic0), 2);
    exec(0, 11'h45); exec(0, 11'h15); exec(0, 11'h15); exec(0, 11'h59); exec(0, 11'h28);
    dbg_sel = 3'd0;
    #1;
    chk("zr0_cvalid", 32'(cv0), 1);
    chk("zr0_cdata", 32'(cd0), 'h0A);
    chk("zr0_dbg_r0", 32'(dd0), 'h0A);
    exec(1, 11'h45); exec(1, 11'h15); exec(1, 11'h15); exec(1, 11'h59); exec(1, 11'h28);
    chk("zr1_no_pulse", 32'(cv1), 0);
    chk("zr1_cdata", 32'(cd1), 5);
    chk("zr1_dbg_r0", 32'(dd1), 0);
    chk("zr1_cnt", 32'(ic1), 5);
    exec(2, 11'h20F);
    chk("w_ld_neg_wrap", 32'(cd2), 'h3F);
    repeat (10) exec(2, 11'h049);
    chk("w_add_shift", 32'(cd2), 'hFC00);
    exec(2, 11'h049);
    chk("w_add_wrap", 32'(cd2), 'hF800);
    exec(2, 11'h253);
    chk("w_ld_wrap64", 32'(cd2), 3);
    dbg_sel = 3'd2;
    #1 chk("w_dbg_r2", 32'(dd2), 3);
    chk("w_cnt", 32'(ic2), 13);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/param_microprocessor_core.md
# param_microprocessor_core

Parametrised multi-cycle load/store core: configurable data width, register-file size and data-memory depth, an external instruction-fetch handshake, conditional branches, an optional hard-wired zero register, a console-write strobe and a debug register read port. It takes its clock directly from the board-level clock generator and drives the seven-segment console logic through `console_data`/`console_valid`. Instruction memory sits outside the block and is reached over a request/valid handshake.

## Interface
- `DATA_W`, 8, datapath, register and data-memory word width
- `RA_W`, 2, register-address width; register file holds 2^RA_W entries; instruction width is 2+3*RA_W
- `PC_W`, 8, program-counter width
- `DMEM_DEPTH`, 32, data-memory entries; must be a power of 2
- `ZERO_REG`, 0, 1 = register 0 reads as 0 and ignores writes
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `run`  in  1  1 = fetch next instruction; 0 = pause in FETCH
- `instr_req`  out  1  instruction request, high throughout WAIT
- `instr_addr`  out  PC_W  equals PC
- `instr_valid`  in  1  instruction data valid, sampled in WAIT
- `instr_data`  in  2+3*RA_W  instruction word
- `console_data`  out  DATA_W  last register write-back value
- `console_valid`  out  1  one-cycle pulse after each register write
- `instr_count`  out  16  retired-instruction counter, wraps
- `dbg_sel`  in  RA_W  debug register select
- `dbg_data`  out  DATA_W  combinational read of GPR[dbg_sel], with ZERO_REG applied

## Operation
- Instruction fields, MSB first: `op`[2], `rs`[RA_W], `rt`[RA_W], `rd/imm`[RA_W]. `imm` is sign-extended to DATA_W for the ALU and to PC_W for branches.
- op 00, ADD: GPR[rd] = GPR[rs] + GPR[rt], mod 2^DATA_W.
- op 01, LOAD: GPR[rt] = MEM[(GPR[rs] + sext(imm)) mod DMEM_DEPTH].
- op 10, STORE: MEM[(GPR[rs] + sext(imm)) mod DMEM_DEPTH] = GPR[rt]. No register write.
- op 11, BEQ: if GPR[rs] == GPR[rt], PC = PC + 1 + sext(imm); otherwise PC = PC + 1. All PC arithmetic is mod 2^PC_W. No register write.
- Address wrap uses the low log2(DMEM_DEPTH) bits of the sum.
- With ZERO_REG=1, a write targeting register 0 is discarded and no console pulse is produced.
- FSM states:
  - FETCH: if run=1, go to WAIT; else stay in FETCH.
  - WAIT: `instr_req`=1; on an edge with `instr_valid`=1, latch IR and go to EXEC; else stay.
  - EXEC: perform write-back or store, update PC, increment `instr_count`, go to FETCH.
- Reset contents: PC, all GPRs, IR, `instr_count` and `console_data` = 0; MEM[i] = i mod 2^DATA_W for every i; state = FETCH.

## Timing
- Reset values: `instr_req`=0, `instr_addr`=0, `console_valid`=0, `console_data`=0, `instr_count`=0.
- Reset is asynchronous: it clears everything immediately in any state. An instruction in flight in WAIT is dropped and the first fetch after reset release is from address 0.
- `instr_req` is a registered state decode: high from the edge entering WAIT until the edge on which `instr_valid`=1 is sampled.
- `instr_valid` outside WAIT is ignored.
- Minimum instruction time is 3 cycles (FETCH, WAIT, EXEC) when `instr_valid` is already high on the first WAIT cycle.
- GPR, MEM, PC and `instr_count` update on the edge ending EXEC.
- `console_data`/`console_valid` update on that same edge; `console_valid` is high for exactly the following cycle.
- The GPR read in EXEC sees pre-write values. A LOAD whose destination is also `rs` uses the old `rs` for the address.
- `run` is sampled only in FETCH. Deasserting it during WAIT/EXEC completes the current instruction.
- `dbg_data` is combinational; a register write becomes visible on it the cycle after EXEC.

## Test plan
- Reset, then `instr_data`=0x46 (LOAD rs=0 rt=1 imm=-2): address 0xFE mod 32 = 30 -> r1=0x1E; `console_valid` pulses with 0x1E; `instr_count`=1; PC=1.
- Next, 0x15 (ADD r1=r1+r1) -> r1=0x3C, console shows 0x3C. Then 0x94 (STORE rs=1 rt=1 imm=0) writes MEM[28]=0x3C with no console pulse. Then 0x58 (LOAD r2=MEM[r1]) -> r2=0x3C.
- BEQ: with r0=r3=0 at PC=5, 0xC1 -> PC=7. With r1=0x3C, 0xC7 (rs=0 rt=1 imm=-1) is not taken -> PC=8. At PC=0xFF, taken BEQ with imm=+1 -> PC wraps to 0x01.
- Handshake: hold `instr_valid` low for 5 cycles in WAIT -> `instr_req` stays high and `instr_count` is unchanged. With `run`=0 the core stays in FETCH and `instr_req`=0. Asserting reset mid-WAIT drops `instr_req` immediately and the next fetch is from address 0.
- ZERO_REG=1: ADD with rd=0 of 5+5 -> `dbg_sel`=0 returns 0 and no console pulse occurs. With ZERO_REG=0 the same instruction gives 0x0A.
- Width sweep with DATA_W=16, RA_W=3, DMEM_DEPTH=64: ADD 0xFFFF+2 -> 0x0001; LOAD addressing wraps mod 64; instruction width is 11.
